rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Multi-domain reset sequencer for the DCE clock/reset tree. It sits downstream of the top-level clock/reset generator and drives NUM_DOM per-domain active-low resets and clock enables. On power-on, and on software request, it asserts reset on the selected domains with their clocks running, then gates their clocks. It then releases the resets one domain at a time in ascending index order, and finally ungates the clocks.

## Interface
- NUM_DOM, 4: number of reset domains (1..16).
- ASSERT_CYCLES, 10: cycles that dom_rst_n is held low with the clock running (≥2).
- GAP_CYCLES, 2: cycles per gate step, per release slot and per ungate step (≥1).
- CNT_W, 8: counter width; must hold max(ASSERT_CYCLES, GAP_CYCLES)-1.

Ports:
- clk_fr  in  1  clock; all logic on the posedge.
- rst  in  1  synchronous, active-high reset.
- sw_rst_req  in  1  single-cycle reset request.
- sw_rst_mask  in  NUM_DOM  domains to reset; sampled together with sw_rst_req.
- dom_rst_n  out  NUM_DOM  per-domain reset, active low.
- dom_clk_en  out  NUM_DOM  per-domain clock enable.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at the end of a sequence.
- err_ovr  out  1  one-cycle pulse when a request arrives while busy.

## Operation
- FSM states: IDLE, ASSERT, GATE, RELEASE, UNGATE, DONE. All outputs are registered.
- **Reset (rst=1):**
  - State is forced to ASSERT, mask to all ones, cnt to ASSERT_CYCLES-1, idx to 0.
  - Outputs: dom_rst_n=0, dom_clk_en=all ones, busy=1, done=0, err_ovr=0.
  - When rst falls, the power-on sequence continues from ASSERT.
- **ASSERT:**
  - Masked domains have dom_rst_n=0 and dom_clk_en=1.
  - cnt decrements each cycle. When cnt==0, the FSM goes to GATE and loads cnt=GAP_CYCLES-1.
- **GATE:**
  - Entry clears dom_clk_en for masked domains.
  - When cnt==0, the FSM goes to RELEASE with idx=0.
- **RELEASE:**
  - One slot of GAP_CYCLES cycles per index, for every index 0..NUM_DOM-1. Unmasked indices still consume their slot.
  - Slot entry sets dom_rst_n[idx]=1 if mask[idx]=1.
  - After the last slot, the FSM goes to UNGATE.
- **UNGATE:**
  - Entry sets dom_clk_en=1 for masked domains.
  - After GAP_CYCLES cycles, the FSM goes to DONE.
- **DONE:** done=1 for one cycle, then IDLE. busy falls on IDLE entry.
- **IDLE request handling:**
  - sw_rst_req=1 with sw_rst_mask≠0: latch the mask, go to ASSERT, load cnt=ASSERT_CYCLES-1.
  - sw_rst_req=1 with mask==0: ignored, with no error.
- **Unmasked domains** keep their outputs unchanged throughout the sequence.
- **Boundary conditions:**
  - sw_rst_req in any state other than IDLE: ignored, err_ovr pulses on the next cycle, latched mask unchanged.
  - rst and sw_rst_req in the same cycle: rst wins.
  - rst mid-sequence: abort immediately and restart the full power-on sequence.

## Timing
- Edge 0 is the first posedge with rst sampled low (power-on); for a software request, edge k is the posedge that samples the request.
- **Power-on, gating compiled in:**
  - GATE entered at edge ASSERT_CYCLES-1.
  - RELEASE entered at ASSERT_CYCLES-1+GAP_CYCLES.
  - dom_rst_n[i] rises at that edge plus i*GAP_CYCLES.
  - UNGATE entered NUM_DOM*GAP_CYCLES after RELEASE entry.
  - DONE entered GAP_CYCLES after UNGATE entry.
- **Software request:**
  - dom_rst_n falls at edge k.
  - All power-on edges apply shifted by k+1.
- **Total busy cycles:**
  - ASSERT_CYCLES+(NUM_DOM+2)*GAP_CYCLES+1 with gating.
  - ASSERT_CYCLES+NUM_DOM*GAP_CYCLES+1 without gating.

## Configuration
- RST_SEQ_CLK_GATE_EN defined:
  - GATE and UNGATE states are present.
  - dom_clk_en is low for masked domains from GATE entry until UNGATE entry.
- RST_SEQ_CLK_GATE_EN not defined:
  - ASSERT goes directly to RELEASE, and RELEASE goes directly to DONE.
  - dom_clk_en is tied to all ones.
  - All RELEASE timings move GAP_CYCLES earlier.

## Test plan
- Power-on, defaults, gating on: rst high 5 cycles, then low.
  - dom_rst_n bits rise at edges 11, 13, 15, 17.
  - dom_clk_en low over edges 9..18, high again at edge 19.
  - done at edge 21; busy=0 from edge 22.
- Power-on with gating off: dom_rst_n bits rise at edges 9, 11, 13, 15; done at edge 17; dom_clk_en always 4'hF.
- Software request in IDLE with mask 4'b0101 at edge k:
  - Bits 0 and 2 fall at k and rise at k+12 and k+16.
  - Bits 1 and 3 stay 1.
  - dom_clk_en[1] and dom_clk_en[3] stay 1.
- Request while busy, at ASSERT cycle 3: err_ovr pulses one cycle; the sequence timing and mask are unchanged.
- Request with mask 4'b0000: no busy, no done, no err_ovr.
- rst asserted during RELEASE after bit 0 has released:
  - All dom_rst_n=0 and dom_clk_en=4'hF on the next cycle.
  - The full power-on sequence repeats with the timing above.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer: asserts, gates, releases in index order, then ungates per-domain resets/clocks.
// Optional clock gating phases are compiled in with the RST_SEQ_CLK_GATE_EN macro.
module rst_seq_ctrl #(
    parameter int NUM_DOM       = 4,
    parameter int ASSERT_CYCLES = 10,
    parameter int GAP_CYCLES    = 2,
    parameter int CNT_W         = 8
) (
    input  logic               clk_fr,
    input  logic               rst,
    input  logic               sw_rst_req,
    input  logic [NUM_DOM-1:0] sw_rst_mask,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic [NUM_DOM-1:0] dom_clk_en,
    output logic               busy,
    output logic               done,
    output logic               err_ovr
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [CNT_W-1:0] ASSERT_LOAD = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DOM - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        GATE    = 3'd2,
        RELEASE = 3'd3,
        UNGATE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state_r;
    logic [NUM_DOM-1:0] mask_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;

    // One-hot selector for the domain owning a release slot.
    function automatic logic [NUM_DOM-1:0] slot_bit(input logic [IDX_W-1:0] idx);
        slot_bit = {{(NUM_DOM-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_fr) begin
        if (rst) begin
            state_r    <= ASSERT;
            mask_r     <= '1;
            cnt_r      <= ASSERT_LOAD;
            idx_r      <= '0;
            dom_rst_n  <= '0;
            dom_clk_en <= '1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_ovr    <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_ovr <= sw_rst_req && (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (sw_rst_req && (sw_rst_mask != '0)) begin
                        mask_r    <= sw_rst_mask;
                        state_r   <= ASSERT;
                        cnt_r     <= ASSERT_LOAD;
                        dom_rst_n <= dom_rst_n & ~sw_rst_mask;
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ASSERT: begin
                    dom_rst_n <= dom_rst_n & ~mask_r;
                    if (cnt_r == '0) begin
                        cnt_r <= GAP_LOAD;
`ifdef RST_SEQ_CLK_GATE_EN
                        state_r    <= GATE;
                        dom_clk_en <= dom_clk_en & ~mask_r;
`else
                        state_r   <= RELEASE;
                        idx_r     <= '0;
                        dom_rst_n <= (dom_rst_n & ~mask_r) | (mask_r & slot_bit('0));
`endif
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
`ifdef RST_SEQ_CLK_GATE_EN
                GATE: begin
                    if (cnt_r == '0) begin
                        state_r   <= RELEASE;
                        cnt_r     <= GAP_LOAD;
                        idx_r     <= '0;
                        dom_rst_n <= dom_rst_n | (mask_r & slot_bit('0));
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
`endif
                RELEASE: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - 1'b1;
                    end else if (idx_r == LAST_IDX) begin
`ifdef RST_SEQ_CLK_GATE_EN
                        state_r    <= UNGATE;
                        cnt_r      <= GAP_LOAD;
                        dom_clk_en <= dom_clk_en | mask_r;
`else
                        state_r <= DONE;
                        done    <= 1'b1;
`endif
                    end else begin
                        // Unmasked indices still burn their slot; they just release nothing.
                        idx_r     <= idx_r + 1'b1;
                        cnt_r     <= GAP_LOAD;
                        dom_rst_n <= dom_rst_n | (mask_r & slot_bit(idx_r + 1'b1));
                    end
                end
`ifdef RST_SEQ_CLK_GATE_EN
                UNGATE: begin
                    if (cnt_r == '0) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
`endif
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: power-on vector table, directed corner sequences,
// and randomized traffic against a timeline model derived from the sequence edge formulas.
module tb_rst_seq_ctrl;

    localparam int N = 4;
    localparam int A = 10;
    localparam int G = 2;
`ifdef RST_SEQ_CLK_GATE_EN
    localparam int GG = 1;
`else
    localparam int GG = 0;
`endif
    localparam int RISE0    = A - 1 + GG * G;
    localparam int UNGATE_T = RISE0 + N * G;
    localparam int DONE_T   = UNGATE_T + GG * G;

    logic         clk_fr = 1'b0;
    logic         rst = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic [N-1:0] sw_rst_mask = '0;
    logic [N-1:0] dom_rst_n;
    logic [N-1:0] dom_clk_en;
    logic         busy;
    logic         done;
    logic         err_ovr;

    int n_tests = 0;
    int n_fail  = 0;

    rst_seq_ctrl #(.NUM_DOM(N), .ASSERT_CYCLES(A), .GAP_CYCLES(G), .CNT_W(8)) dut (
        .clk_fr(clk_fr), .rst(rst), .sw_rst_req(sw_rst_req), .sw_rst_mask(sw_rst_mask),
        .dom_rst_n(dom_rst_n), .dom_clk_en(dom_clk_en), .busy(busy), .done(done), .err_ovr(err_ovr)
    );

    always #5 clk_fr = ~clk_fr;

    // Reference model: outputs as a function of time since the sequence's edge 0.
    int         cyc = 0;
    logic       m_active = 1'b0;
    int         m_t0 = 0;
    logic [N-1:0] m_mask = '0, m_rst_n = '0, m_clk_en = '1;
    logic       m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;

    task automatic model_edge(input logic r, input logic q, input logic [N-1:0] mk);
        int t;
        if (r) begin
            m_active = 1'b1; m_t0 = cyc + 1; m_mask = '1;
            m_rst_n = '0; m_clk_en = '1; m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_err  = q && m_active;
            m_done = 1'b0;
            if (!m_active && q && (mk != '0)) begin
                m_active = 1'b1; m_mask = mk; m_t0 = cyc + 1;
            end
            if (m_active) begin
                t = cyc - m_t0;
                if (t > DONE_T) begin
                    m_active = 1'b0; m_busy = 1'b0;
                    m_rst_n = m_rst_n | m_mask; m_clk_en = '1;
                end else begin
                    m_busy = 1'b1;
                    m_done = (t == DONE_T);
                    for (int i = 0; i < N; i++) begin
                        if (m_mask[i]) begin
                            m_rst_n[i]  = (t >= RISE0 + i * G);
                            m_clk_en[i] = !((GG == 1) && (t >= A - 1) && (t < UNGATE_T));
                        end
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic q, input logic [N-1:0] mk);
        rst = r; sw_rst_req = q; sw_rst_mask = mk;
        @(posedge clk_fr);
        model_edge(r, q, mk);
        @(negedge clk_fr);
        chk("model_rst_n", 32'(dom_rst_n), 32'(m_rst_n));
        chk("model_clk_en", 32'(dom_clk_en), 32'(m_clk_en));
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_err", 32'(err_ovr), 32'(m_err));
    endtask

    typedef struct {
        int           e;
        logic [N-1:0] rst_n;
        logic [N-1:0] clk_en;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl[11];
    int   nrec;

    // Hold rst, release it, then walk the power-on vector table.
    task automatic run_power_on(input int hold);
        int pos;
        for (int i = 0; i < hold; i++) step(1'b1, 1'b0, '0);
        chk("reset_rst_n", 32'(dom_rst_n), 32'h0);
        chk("reset_clk_en", 32'(dom_clk_en), 32'hF);
        chk("reset_busy", 32'(busy), 32'h1);
        pos = 0;
        for (int r = 0; r < nrec; r++) begin
            while (pos <= tbl[r].e) begin
                step(1'b0, 1'b0, '0);
                pos++;
            end
            chk($sformatf("po_rst_n_e%0d", tbl[r].e), 32'(dom_rst_n), 32'(tbl[r].rst_n));
            chk($sformatf("po_clk_en_e%0d", tbl[r].e), 32'(dom_clk_en), 32'(tbl[r].clk_en));
            chk($sformatf("po_busy_e%0d", tbl[r].e), 32'(busy), 32'(tbl[r].busy));
            chk($sformatf("po_done_e%0d", tbl[r].e), 32'(done), 32'(tbl[r].done));
        end
    endtask

    logic [N-1:0] hist_rst [0:40];
    logic [N-1:0] hist_clk [0:40];
    logic         bad;

    initial begin
`ifdef RST_SEQ_CLK_GATE_EN
        tbl[0]  = '{8,  4'b0000, 4'b1111, 1'b1, 1'b0};
        tbl[1]  = '{9,  4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[2]  = '{11, 4'b0001, 4'b0000, 1'b1, 1'b0};
        tbl[3]  = '{12, 4'b0001, 4'b0000, 1'b1, 1'b0};
        tbl[4]  = '{13, 4'b0011, 4'b0000, 1'b1, 1'b0};
        tbl[5]  = '{15, 4'b0111, 4'b0000, 1'b1, 1'b0};
        tbl[6]  = '{17, 4'b1111, 4'b0000, 1'b1, 1'b0};
        tbl[7]  = '{18, 4'b1111, 4'b0000, 1'b1, 1'b0};
        tbl[8]  = '{19, 4'b1111, 4'b1111, 1'b1, 1'b0};
        tbl[9]  = '{21, 4'b1111, 4'b1111, 1'b1, 1'b1};
        tbl[10] = '{22, 4'b1111, 4'b1111, 1'b0, 1'b0};
        nrec = 11;
`else
        tbl[0]  = '{8,  4'b0000, 4'b1111, 1'b1, 1'b0};
        tbl[1]  = '{9,  4'b0001, 4'b1111, 1'b1, 1'b0};
        tbl[2]  = '{10, 4'b0001, 4'b1111, 1'b1, 1'b0};
        tbl[3]  = '{11, 4'b0011, 4'b1111, 1'b1, 1'b0};
        tbl[4]  = '{13, 4'b0111, 4'b1111, 1'b1, 1'b0};
        tbl[5]  = '{15, 4'b1111, 4'b1111, 1'b1, 1'b0};
        tbl[6]  = '{16, 4'b1111, 4'b1111, 1'b1, 1'b0};
        tbl[7]  = '{17, 4'b1111, 4'b1111, 1'b1, 1'b1};
        tbl[8]  = '{18, 4'b1111, 4'b1111, 1'b0, 1'b0};
        tbl[9]  = '{19, 4'b1111, 4'b1111, 1'b0, 1'b0};
        tbl[10] = '{20, 4'b1111, 4'b1111, 1'b0, 1'b0};
        nrec = 11;
`endif

        run_power_on(5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

        // Software request with a partial mask.
        step(1'b0, 1'b1, 4'b0101);
        hist_rst[0] = dom_rst_n; hist_clk[0] = dom_clk_en;
        for (int j = 1; j <= 40; j++) begin
            step(1'b0, 1'b0, '0);
            hist_rst[j] = dom_rst_n; hist_clk[j] = dom_clk_en;
        end
        chk("sw_fall_k", 32'(hist_rst[0]), 32'hA);
        chk("sw_bit0_before", 32'(hist_rst[RISE0][0]), 32'h0);
        chk("sw_bit0_rise", 32'(hist_rst[RISE0 + 1][0]), 32'h1);
        chk("sw_bit2_before", 32'(hist_rst[RISE0 + 2 * G][2]), 32'h0);
        chk("sw_bit2_rise", 32'(hist_rst[RISE0 + 1 + 2 * G][2]), 32'h1);
        bad = 1'b0;
        for (int j = 0; j <= 40; j++)
            if (!hist_rst[j][1] || !hist_rst[j][3] || !hist_clk[j][1] || !hist_clk[j][3]) bad = 1'b1;
        chk("sw_unmasked_hold", 32'(bad), 32'h0);

        // Overrun request during ASSERT.
        step(1'b0, 1'b1, 4'b0101);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 4'b0010);
        chk("ovr_err_pulse", 32'(err_ovr), 32'h1);
        hist_rst[3] = dom_rst_n;
        step(1'b0, 1'b0, '0);
        chk("ovr_err_clear", 32'(err_ovr), 32'h0);
        for (int j = 5; j <= 40; j++) begin
            step(1'b0, 1'b0, '0);
            hist_rst[j] = dom_rst_n;
        end
        chk("ovr_mask_kept", 32'(hist_rst[3][1]), 32'h1);
        chk("ovr_bit0_rise", 32'(hist_rst[RISE0 + 1][0]), 32'h1);
        chk("ovr_bit0_before", 32'(hist_rst[RISE0][0]), 32'h0);

        // Empty mask is silently ignored.
        step(1'b0, 1'b1, 4'b0000);
        bad = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (busy || done || err_ovr) bad = 1'b1;
            step(1'b0, 1'b0, '0);
        end
        chk("zero_mask_quiet", 32'(bad), 32'h0);

        // rst during RELEASE after bit 0 released, with a simultaneous request.
        step(1'b0, 1'b1, 4'b1111);
        for (int j = 1; j <= RISE0 + 2; j++) step(1'b0, 1'b0, '0);
        chk("mid_bit0_released", 32'(dom_rst_n[0]), 32'h1);
        step(1'b1, 1'b1, 4'b0011);
        chk("mid_abort_rst_n", 32'(dom_rst_n), 32'h0);
        chk("mid_abort_clk_en", 32'(dom_clk_en), 32'hF);
        run_power_on(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, q;
            r = ($urandom_range(0, 399) == 0);
            q = ($urandom_range(0, 7) == 0);
            step(r, q, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
